// File: rtl/ball_motion_if.sv
// ball_motion_if
// Groups the frame-update controls and the registered ball-state outputs of
// ball_motion_ctrl into one bundle.
//   start, tick, left, right, land : controls from the debouncers and the
//                                    collision checker (master -> slave)
//   x_ball, y_ball, vy, state, dead : ball state towards the renderer
//                                    (slave -> master)
// The slave modport is the motion engine; the master modport is its driver.
interface ball_motion_if #(
    parameter int X_W  = 10,
    parameter int Y_W  = 16,
    parameter int VY_W = 8
);
    logic                   start;
    logic                   tick;
    logic                   left;
    logic                   right;
    logic                   land;
    logic [X_W-1:0]         x_ball;
    logic [Y_W-1:0]         y_ball;
    logic signed [VY_W-1:0] vy;
    logic [1:0]             state;
    logic                   dead;

    modport master (
        output start, tick, left, right, land,
        input  x_ball, y_ball, vy, state, dead
    );

    modport slave (
        input  start, tick, left, right, land,
        output x_ball, y_ball, vy, state, dead
    );
endinterface

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl
// Registered ball-position engine for the jump game. Once per frame tick the
// ball moves horizontally from left/right requests and vertically under
// gravity, bouncing when the collision checker reports platform contact and
// dying when it falls below y = 0.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low reset
//   bus    : ball_motion_if.slave
//            in : start, tick, left, right, land
//            out: x_ball, y_ball, vy (signed), state (IDLE/RISING/FALLING/DEAD),
//                 dead
module ball_motion_ctrl #(
    parameter int X_W     = 10,
    parameter int Y_W     = 16,
    parameter int VY_W    = 8,
    parameter int X_MIN   = 0,
    parameter int X_MAX   = 639,
    parameter int X_START = 320,
    parameter int Y_START = 100,
    parameter int X_STEP  = 4,
    parameter int GRAVITY = 1,
    parameter int JUMP_V  = 20,
    parameter int VY_MAX  = 24,
    parameter int WRAP_X  = 0
) (
    input  logic          clk,
    input  logic          reset,
    ball_motion_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RISING  = 2'd1,
        FALLING = 2'd2,
        DEAD    = 2'd3
    } state_t;

    // Two spare bits on x keep both the borrow below X_MIN and the sign
    // visible; two on y hold y + vy without overflow plus its sign.
    localparam int XS_W = X_W + 2;
    localparam int YS_W = Y_W + 2;
    localparam int VS_W = VY_W + 1;

    localparam logic signed [VS_W-1:0] VY_FLOOR = -$signed(VS_W'(VY_MAX));

    state_t                 state_reg, state_next;
    logic [X_W-1:0]         x_reg, x_next;
    logic [Y_W-1:0]         y_reg, y_next;
    logic signed [VY_W-1:0] vy_reg, vy_next;
    logic                   dead_reg;

    logic [X_W-1:0]         x_step;
    logic signed [YS_W-1:0] y_sum;
    logic signed [VY_W-1:0] vy_step;
    logic                   vy_step_nonpos;

    // Horizontal move with saturation or wrap at the playfield edges.
    function automatic logic [X_W-1:0] step_x(
        input logic [X_W-1:0] x,
        input logic           mv_left,
        input logic           mv_right
    );
        logic signed [XS_W-1:0] sum;
        sum = $signed({2'b00, x});
        if (mv_left && !mv_right)
            sum = sum - $signed(XS_W'(X_STEP));
        else if (mv_right && !mv_left)
            sum = sum + $signed(XS_W'(X_STEP));

        if (sum < $signed(XS_W'(X_MIN)))
            step_x = (WRAP_X != 0) ? X_W'(X_MAX) : X_W'(X_MIN);
        else if (sum > $signed(XS_W'(X_MAX)))
            step_x = (WRAP_X != 0) ? X_W'(X_MIN) : X_W'(X_MAX);
        else
            step_x = sum[X_W-1:0];
    endfunction

    function automatic logic signed [YS_W-1:0] add_y(
        input logic [Y_W-1:0]         y,
        input logic signed [VY_W-1:0] v
    );
        add_y = $signed({2'b00, y}) + $signed({{(YS_W-VY_W){v[VY_W-1]}}, v});
    endfunction

    // Clips a non-negative y + vy to the top of the world.
    function automatic logic [Y_W-1:0] sat_y(input logic signed [YS_W-1:0] s);
        if (!s[YS_W-1] && (s[YS_W-2:Y_W] != '0))
            sat_y = {Y_W{1'b1}};
        else
            sat_y = s[Y_W-1:0];
    endfunction

    // Gravity with terminal fall speed.
    function automatic logic signed [VY_W-1:0] fall_vy(input logic signed [VY_W-1:0] v);
        logic signed [VS_W-1:0] d;
        d = $signed({v[VY_W-1], v}) - $signed(VS_W'(GRAVITY));
        if (d < VY_FLOOR)
            d = VY_FLOOR;
        fall_vy = d[VY_W-1:0];
    endfunction

    assign x_step         = step_x(x_reg, bus.left, bus.right);
    assign y_sum          = add_y(y_reg, vy_reg);
    assign vy_step        = fall_vy(vy_reg);
    assign vy_step_nonpos = vy_step[VY_W-1] || (vy_step == '0);

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        vy_next    = vy_reg;
        unique case (state_reg)
            IDLE: begin
                // start wins over a coincident tick: launch without moving.
                if (bus.start) begin
                    state_next = RISING;
                    vy_next    = VY_W'(JUMP_V);
                end
            end
            RISING: begin
                if (bus.tick) begin
                    x_next  = x_step;
                    y_next  = sat_y(y_sum);
                    vy_next = vy_step;
                    if (vy_step_nonpos)
                        state_next = FALLING;
                end
            end
            FALLING: begin
                if (bus.tick) begin
                    if (bus.land) begin
                        // Bounce: keep height, relaunch upward.
                        x_next     = x_step;
                        vy_next    = VY_W'(JUMP_V);
                        state_next = RISING;
                    end else if (y_sum[YS_W-1]) begin
                        // Fell through the floor: freeze x, pin to ground.
                        y_next     = '0;
                        vy_next    = '0;
                        state_next = DEAD;
                    end else begin
                        x_next  = x_step;
                        y_next  = sat_y(y_sum);
                        vy_next = vy_step;
                    end
                end
            end
            DEAD: begin
                if (bus.start) begin
                    x_next     = X_W'(X_START);
                    y_next     = Y_W'(Y_START);
                    vy_next    = VY_W'(JUMP_V);
                    state_next = RISING;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            x_reg     <= X_W'(X_START);
            y_reg     <= Y_W'(Y_START);
            vy_reg    <= '0;
            dead_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            vy_reg    <= vy_next;
            dead_reg  <= (state_next == DEAD);
        end
    end

    assign bus.x_ball = x_reg;
    assign bus.y_ball = y_reg;
    assign bus.vy     = vy_reg;
    assign bus.state  = state_reg;
    assign bus.dead   = dead_reg;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb_ball_motion_ctrl
// Drives a saturating (WRAP_X=0) and a wrapping (WRAP_X=1) instance of
// ball_motion_ctrl with identical controls and compares both against a
// behavioural model of the ball game kept in plain integers.
module tb_ball_motion_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ball_motion_if bus0 ();
    ball_motion_if bus1 ();

    ball_motion_ctrl #(.WRAP_X(0)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    ball_motion_ctrl #(.WRAP_X(1)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (game-level quantities).
    int m_x_sat, m_x_wrap, m_y, m_vy, m_st;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int move_x(input int x, input bit l, input bit r, input bit wrap);
        int n;
        if (l == r) return x;
        n = l ? x - 4 : x + 4;
        if (n < 0)   return wrap ? 639 : 0;
        if (n > 639) return wrap ? 0 : 639;
        return n;
    endfunction

    task automatic model_reset();
        m_x_sat = 320; m_x_wrap = 320; m_y = 100; m_vy = 0; m_st = 0;
    endtask

    task automatic model_step(input bit s, input bit t, input bit l, input bit r, input bit ld);
        int yn, vyn;
        yn  = m_y + m_vy;
        vyn = m_vy - 1;
        if (vyn < -24) vyn = -24;
        case (m_st)
            0: if (s) begin m_st = 1; m_vy = 20; end
            3: if (s) begin
                   m_x_sat = 320; m_x_wrap = 320; m_y = 100; m_vy = 20; m_st = 1;
               end
            1: if (t) begin
                   m_x_sat  = move_x(m_x_sat, l, r, 1'b0);
                   m_x_wrap = move_x(m_x_wrap, l, r, 1'b1);
                   m_y  = (yn > 65535) ? 65535 : yn;
                   m_vy = vyn;
                   if (vyn <= 0) m_st = 2;
               end
            default: if (t) begin
                   if (ld) begin
                       m_x_sat  = move_x(m_x_sat, l, r, 1'b0);
                       m_x_wrap = move_x(m_x_wrap, l, r, 1'b1);
                       m_vy = 20; m_st = 1;
                   end else if (yn < 0) begin
                       m_y = 0; m_vy = 0; m_st = 3;
                   end else begin
                       m_x_sat  = move_x(m_x_sat, l, r, 1'b0);
                       m_x_wrap = move_x(m_x_wrap, l, r, 1'b1);
                       m_y  = (yn > 65535) ? 65535 : yn;
                       m_vy = vyn;
                   end
               end
        endcase
    endtask

    task automatic check_all();
        check_eq("x_sat",  int'(bus0.x_ball), m_x_sat);
        check_eq("x_wrap", int'(bus1.x_ball), m_x_wrap);
        check_eq("y",      int'(bus0.y_ball), m_y);
        check_eq("vy",     int'(bus0.vy),     m_vy);
        check_eq("state",  int'(bus0.state),  m_st);
        check_eq("dead",   int'(bus0.dead),   (m_st == 3) ? 1 : 0);
        check_eq("y_wrap", int'(bus1.y_ball), m_y);
    endtask

    task automatic drive(input bit s, input bit t, input bit l, input bit r, input bit ld);
        bus0.start = s; bus0.tick = t; bus0.left = l; bus0.right = r; bus0.land = ld;
        bus1.start = s; bus1.tick = t; bus1.left = l; bus1.right = r; bus1.land = ld;
    endtask

    task automatic cycle(input bit s, input bit t, input bit l, input bit r, input bit ld);
        drive(s, t, l, r, ld);
        @(posedge clk);
        model_step(s, t, l, r, ld);
        #1;
        check_all();
    endtask

    // Assert reset between clock edges and check it takes effect at once.
    task automatic mid_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    int vmin, ymax, k;

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check_eq("rst_x", int'(bus0.x_ball), 320);
        check_eq("rst_state", int'(bus0.state), 0);
        @(negedge clk);
        reset = 1'b1;

        // Start with a coincident tick and right: launch only, no motion.
        cycle(1, 1, 0, 1, 0);
        check_eq("t6_state", int'(bus0.state), 1);
        check_eq("t6_vy", int'(bus0.vy), 20);
        check_eq("t6_y", int'(bus0.y_ball), 100);
        check_eq("t6_x", int'(bus0.x_ball), 320);

        // 20 ticks of free rise; idle cycles in between must not move.
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1, 0, 0, 0);
            cycle(1, 0, 1, 0, 1);
        end
        check_eq("t1_y", int'(bus0.y_ball), 310);
        check_eq("t1_vy", int'(bus0.vy), 0);
        check_eq("t1_state", int'(bus0.state), 2);

        // Bounce off a platform.
        cycle(0, 1, 0, 0, 1);
        check_eq("t2_vy", int'(bus0.vy), 20);
        check_eq("t2_y", int'(bus0.y_ball), 310);
        check_eq("t2_state", int'(bus0.state), 1);

        // Right held against the edge; land kept high so the ball survives.
        for (int i = 0; i < 79; i++) cycle(0, 1, 0, 1, 1);
        check_eq("t3_x79_sat", int'(bus0.x_ball), 636);
        check_eq("t3_x79_wrap", int'(bus1.x_ball), 636);
        cycle(0, 1, 0, 1, 1);
        check_eq("t3_x80_sat", int'(bus0.x_ball), 639);
        check_eq("t3_x80_wrap", int'(bus1.x_ball), 0);
        cycle(0, 1, 0, 1, 1);
        check_eq("t3_x81_sat", int'(bus0.x_ball), 639);
        cycle(0, 1, 1, 1, 1);
        check_eq("t3_lr_wrap", int'(bus1.x_ball), 4);
        cycle(0, 1, 1, 0, 1);
        cycle(0, 1, 1, 0, 1);
        check_eq("t3_left_wrap", int'(bus1.x_ball), 639);
        check_eq("t3_left_sat", int'(bus0.x_ball), 631);

        // Free fall to death, bounded.
        vmin = 0;
        k = 0;
        while (bus0.state != 2'd3 && k < 400) begin
            cycle(0, 1, 0, 1, 0);
            if (int'(bus0.vy) < vmin) vmin = int'(bus0.vy);
            k++;
        end
        check_eq("t4_vmin", vmin, -24);
        check_eq("t4_state", int'(bus0.state), 3);
        check_eq("t4_dead", int'(bus0.dead), 1);
        check_eq("t4_y", int'(bus0.y_ball), 0);
        cycle(0, 1, 1, 0, 1);
        cycle(1, 0, 0, 0, 0);
        check_eq("t4_rs_x", int'(bus0.x_ball), 320);
        check_eq("t4_rs_y", int'(bus0.y_ball), 100);
        check_eq("t4_rs_vy", int'(bus0.vy), 20);
        check_eq("t4_rs_state", int'(bus0.state), 1);

        // Reset in the middle of FALLING.
        for (int i = 0; i < 22; i++) cycle(0, 1, 1, 0, 0);
        check_eq("t5_pre_state", int'(bus0.state), 2);
        mid_reset();
        check_eq("t5_x", int'(bus0.x_ball), 320);
        check_eq("t5_y", int'(bus0.y_ball), 100);
        check_eq("t5_vy", int'(bus0.vy), 0);
        check_eq("t5_state", int'(bus0.state), 0);

        // Climb by bouncing at every apex until y hits the world ceiling.
        cycle(1, 0, 0, 0, 0);
        ymax = 0;
        for (int i = 0; i < 7000; i++) begin
            cycle(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
            if (int'(bus0.y_ball) > ymax) ymax = int'(bus0.y_ball);
        end
        check_eq("ceiling", ymax, 65535);
        mid_reset();

        // Random play.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                mid_reset();
            end else begin
                cycle(1'($urandom_range(0, 15) == 0),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 5) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
